display_scan_ctrl: RTL and testbench

// - Time-multiplexed driver for an N-digit common-anode 7-segment display.
// - Scans digits round-robin, drives the shared active-low segment bus and one active-low digit enable.
// - Digit data is double-buffered: writes land in shadow registers and go live only at a frame boundary, so a frame never tears.
// - Sits between the application FSM (writer) and the board display pins. It is the controller that generates the digit select the segment multiplexer consumes.

---
 rtl/display_pkg.sv | 15 +
 rtl/hex_to_seg7.sv | 30 +++
 rtl/display_scan_ctrl.sv | 96 +++++++++
 tb/tb_display_scan_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the 7-segment display blocks.
package display_pkg;

  typedef logic [6:0] seg7_t;

  typedef struct packed {
    logic       dp;
    logic       blank;
    logic [3:0] hex;
  } digit_entry_t;

  localparam seg7_t        SEG_OFF     = 7'h7F;
  localparam digit_entry_t ENTRY_BLANK = 6'b010000;

endpackage

// File: rtl/hex_to_seg7.sv
// Hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}; b and d lowercase.
module hex_to_seg7
  import display_pkg::*;
(
  input  logic [3:0] hex,
  output seg7_t      seg
);

  always_comb begin
    case (hex)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Round-robin scan driver for an N-digit common-anode display with
// double-buffered digit data published only at frame boundaries.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int TICK_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic                        wr_en,
  input  logic [$clog2(N_DIGITS)-1:0] wr_idx,
  input  logic [5:0]                  wr_data,
  input  logic                        commit,
  output logic                        commit_pending,
  output logic                        frame_start,
  output logic [6:0]                  seg_n,
  output logic                        dp_n,
  output logic [N_DIGITS-1:0]         dig_n
);

  localparam int IDX_W = $clog2(N_DIGITS);
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam logic [IDX_W:0]   IDX_LIMIT = (IDX_W + 1)'(N_DIGITS);

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             slot_end, wrap, apply, lit;
  digit_entry_t     shadow [N_DIGITS];
  digit_entry_t     active [N_DIGITS];
  digit_entry_t     entry_nxt;
  seg7_t            seg_dec;

  // Outputs are decoded from next-state so they line up with cnt/idx.
  always_comb begin
    slot_end  = (cnt == CNT_LAST);
    wrap      = slot_end && (idx == IDX_LAST);
    apply     = wrap && commit_pending;
    cnt_nxt   = slot_end ? '0 : cnt + CNT_W'(1);
    idx_nxt   = idx;
    if (slot_end)
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    entry_nxt = apply ? shadow[idx_nxt] : active[idx_nxt];
    lit       = en && (cnt_nxt >= CNT_BLANK);
  end

  hex_to_seg7 u_dec (
    .hex (entry_nxt.hex),
    .seg (seg_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt            <= '0;
      idx            <= '0;
      commit_pending <= 1'b0;
      frame_start    <= 1'b0;
      seg_n          <= SEG_OFF;
      dp_n           <= 1'b1;
      dig_n          <= '1;
      for (int i = 0; i < N_DIGITS; i++) begin
        shadow[i] <= ENTRY_BLANK;
        active[i] <= ENTRY_BLANK;
      end
    end else begin
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      frame_start <= wrap;

      // A commit landing on the wrap edge only arms; it applies next frame.
      if (apply)
        commit_pending <= 1'b0;
      else if (commit)
        commit_pending <= 1'b1;

      if (apply)
        for (int i = 0; i < N_DIGITS; i++)
          active[i] <= shadow[i];

      if (wr_en && ({1'b0, wr_idx} < IDX_LIMIT))
        shadow[wr_idx] <= wr_data;

      dig_n <= '1;
      if (lit)
        dig_n[idx_nxt] <= 1'b0;
      seg_n <= (lit && !entry_nxt.blank) ? seg_dec : SEG_OFF;
      dp_n  <= !(lit && !entry_nxt.blank && entry_nxt.dp);
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl (4-digit main instance, 5-digit range instance).
module tb_display_scan_ctrl;

  typedef struct packed {
    logic [3:0] dig;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
    logic       cp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en, wr_en, commit;
  logic [1:0] wr_idx;
  logic [5:0] wr_data;
  logic       commit_pending, frame_start, dp_n;
  logic [6:0] seg_n;
  logic [3:0] dig_n;

  logic       en5, wr_en5, commit5;
  logic [2:0] wr_idx5;
  logic [5:0] wr_data5;
  logic       cp5, fs5, dp5;
  logic [6:0] seg5;
  logic [4:0] dig5;

  logic [6:0] lut [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [5:0] disp [4];
  exp_t       q [$];
  int         k, checks, passed;

  always #5 clk = ~clk;

  display_scan_ctrl #(.N_DIGITS(4), .TICK_DIV(8), .BLANK_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_data(wr_data), .commit(commit), .commit_pending(commit_pending),
    .frame_start(frame_start), .seg_n(seg_n), .dp_n(dp_n), .dig_n(dig_n)
  );

  display_scan_ctrl #(.N_DIGITS(5), .TICK_DIV(8), .BLANK_CYC(2)) dut5 (
    .clk(clk), .rst_n(rst_n), .en(en5), .wr_en(wr_en5), .wr_idx(wr_idx5),
    .wr_data(wr_data5), .commit(commit5), .commit_pending(cp5),
    .frame_start(fs5), .seg_n(seg5), .dp_n(dp5), .dig_n(dig5)
  );

  // Expected main-instance outputs after the edge that brings the scan to cycle kk.
  function automatic exp_t model(int kk, logic en_v, logic cp_v);
    exp_t       e;
    int         c, i;
    logic       lit;
    logic [5:0] d;
    c     = kk % 8;
    i     = (kk / 8) % 4;
    lit   = en_v && (c >= 2);
    d     = disp[i];
    e.dig = 4'hF;
    if (lit) e.dig[i] = 1'b0;
    e.seg = (lit && !d[4]) ? lut[d[3:0]] : 7'h7F;
    e.dp  = !(lit && !d[4] && d[5]);
    e.fs  = (kk % 32 == 0);
    e.cp  = cp_v;
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic clear_disp;
    for (int i = 0; i < 4; i++) disp[i] = 6'h10;
  endtask

  task automatic test_reset;
    en = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_data = '0; commit = 1'b0;
    en5 = 1'b1; wr_en5 = 1'b0; wr_idx5 = '0; wr_data5 = '0; commit5 = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({dig_n, seg_n, dp_n, frame_start, commit_pending} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_main got %h required %h",
               {dig_n, seg_n, dp_n, frame_start, commit_pending}, {4'hF, 7'h7F, 3'b100});
    else passed++;
    checks++;
    if ({dig5, seg5, dp5, fs5, cp5} !== {5'h1F, 7'h7F, 1'b1, 1'b0, 1'b0})
      $display("FAIL reset_n5 got %h required %h", {dig5, seg5, dp5, fs5, cp5}, {5'h1F, 7'h7F, 3'b100});
    else passed++;
    rst_n = 1'b1;
    k = 0;
    clear_disp();
  endtask

  task automatic test_scan;
    exp_t        e;
    logic [13:0] obs;
    for (int n = 0; n < 64; n++) begin
      q.push_back(model(k + 1, en, 1'b0));
      tick();
      e = q.pop_front();
      obs = {dig_n, seg_n, dp_n, frame_start, commit_pending};
      checks++;
      if (obs !== e) $display("FAIL scan k=%0d got %h required %h", k, obs, e);
      else passed++;
    end
  endtask

  task automatic test_commit;
    exp_t        e;
    logic [13:0] obs;
    logic        cp_e;
    int          kk;
    cp_e = 1'b0;
    for (int n = 0; n < 64; n++) begin
      kk = k + 1;
      wr_en = 1'b0; commit = 1'b0;
      if (kk >= 65 && kk <= 68) begin
        wr_en   = 1'b1;
        wr_idx  = 2'(kk - 65);
        wr_data = (kk == 68) ? 6'h24 : 6'(kk - 64);
      end
      if (kk == 75 || kk == 80) commit = 1'b1;
      if (kk == 75) cp_e = 1'b1;
      if (kk == 96) begin
        cp_e = 1'b0;
        disp[0] = 6'h01; disp[1] = 6'h02; disp[2] = 6'h03; disp[3] = 6'h24;
      end
      q.push_back(model(kk, en, cp_e));
      tick();
      e = q.pop_front();
      obs = {dig_n, seg_n, dp_n, frame_start, commit_pending};
      checks++;
      if (obs !== e) $display("FAIL commit k=%0d got %h required %h", k, obs, e);
      else passed++;
    end
    wr_en = 1'b0; commit = 1'b0;
  endtask

  task automatic test_commit_on_wrap;
    exp_t        e;
    logic [13:0] obs;
    logic        cp_e;
    int          kk;
    cp_e = 1'b0;
    for (int n = 0; n < 72; n++) begin
      kk = k + 1;
      wr_en = 1'b0; commit = 1'b0;
      if (kk >= 129 && kk <= 132) begin
        wr_en   = 1'b1;
        wr_idx  = 2'(kk - 129);
        wr_data = 6'(kk - 124);
      end
      if (kk == 160) begin
        commit = 1'b1;
        cp_e   = 1'b1;
      end
      if (kk == 192) begin
        cp_e = 1'b0;
        disp[0] = 6'h05; disp[1] = 6'h06; disp[2] = 6'h07; disp[3] = 6'h08;
      end
      q.push_back(model(kk, en, cp_e));
      tick();
      e = q.pop_front();
      obs = {dig_n, seg_n, dp_n, frame_start, commit_pending};
      checks++;
      if (obs !== e) $display("FAIL commit_on_wrap k=%0d got %h required %h", k, obs, e);
      else passed++;
    end
    commit = 1'b0;
  endtask

  task automatic test_back_to_back;
    exp_t        e;
    logic [13:0] obs;
    logic        cp_e;
    int          kk;
    cp_e = 1'b0;
    for (int n = 0; n < 70; n++) begin
      kk = k + 1;
      wr_en = 1'b0; commit = 1'b0; wr_idx = 2'd0;
      if (kk == 210) begin wr_en = 1'b1; wr_data = 6'h0C; end
      if (kk == 212 || kk == 230) begin commit = 1'b1; cp_e = 1'b1; end
      if (kk == 224) begin
        wr_en = 1'b1; wr_data = 6'h0A;
        cp_e = 1'b0; disp[0] = 6'h0C;
      end
      if (kk == 256) begin cp_e = 1'b0; disp[0] = 6'h0A; end
      q.push_back(model(kk, en, cp_e));
      tick();
      e = q.pop_front();
      obs = {dig_n, seg_n, dp_n, frame_start, commit_pending};
      checks++;
      if (obs !== e) $display("FAIL wr_on_wrap k=%0d got %h required %h", k, obs, e);
      else passed++;
    end
    wr_en = 1'b0; commit = 1'b0;
  endtask

  task automatic test_en_off;
    exp_t        e;
    logic [13:0] obs;
    int          kk;
    for (int n = 0; n < 30; n++) begin
      kk = k + 1;
      en = (kk >= 275 && kk < 290) ? 1'b0 : 1'b1;
      q.push_back(model(kk, en, 1'b0));
      tick();
      e = q.pop_front();
      obs = {dig_n, seg_n, dp_n, frame_start, commit_pending};
      checks++;
      if (obs !== e) $display("FAIL en_off k=%0d got %h required %h", k, obs, e);
      else passed++;
    end
    en = 1'b1;
  endtask

  task automatic test_out_of_range;
    logic [12:0] q5 [$];
    logic [12:0] e5, obs5;
    logic [5:0]  d;
    logic [4:0]  dg;
    int          kk, c, i;
    for (int n = 0; n < 60; n++) begin
      kk = k + 1;
      wr_en5 = 1'b0; commit5 = 1'b0;
      case (kk)
        301: begin wr_en5 = 1'b1; wr_idx5 = 3'd0; wr_data5 = 6'h02; end
        302: begin wr_en5 = 1'b1; wr_idx5 = 3'd5; wr_data5 = 6'h08; end
        303: begin wr_en5 = 1'b1; wr_idx5 = 3'd6; wr_data5 = 6'h08; end
        304: begin wr_en5 = 1'b1; wr_idx5 = 3'd7; wr_data5 = 6'h08; end
        305: begin wr_en5 = 1'b1; wr_idx5 = 3'd4; wr_data5 = 6'h01; end
        306: commit5 = 1'b1;
        default: ;
      endcase
      c  = kk % 8;
      i  = (kk / 8) % 5;
      d  = 6'h10;
      if (kk >= 320 && i == 0) d = 6'h02;
      if (kk >= 320 && i == 4) d = 6'h01;
      dg = 5'h1F;
      if (c >= 2) dg[i] = 1'b0;
      q5.push_back({dg, (c >= 2 && !d[4]) ? lut[d[3:0]] : 7'h7F, 1'b1});
      tick();
      e5   = q5.pop_front();
      obs5 = {dig5, seg5, dp5};
      checks++;
      if (obs5 !== e5) $display("FAIL out_of_range k=%0d got %h required %h", k, obs5, e5);
      else passed++;
    end
    wr_en5 = 1'b0; commit5 = 1'b0;
  endtask

  task automatic test_reset_mid;
    exp_t        e;
    logic [13:0] obs;
    logic        cp_e;
    int          kk;
    cp_e = 1'b0;
    for (int n = 0; n < 5; n++) begin
      kk = k + 1;
      wr_en = 1'b0; commit = 1'b0;
      if (kk == 361) begin wr_en = 1'b1; wr_idx = 2'd1; wr_data = 6'h0F; end
      if (kk == 362) begin commit = 1'b1; cp_e = 1'b1; end
      q.push_back(model(kk, en, cp_e));
      tick();
      e = q.pop_front();
      obs = {dig_n, seg_n, dp_n, frame_start, commit_pending};
      checks++;
      if (obs !== e) $display("FAIL pre_reset k=%0d got %h required %h", k, obs, e);
      else passed++;
    end
    wr_en = 1'b0; commit = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    obs = {dig_n, seg_n, dp_n, frame_start, commit_pending};
    checks++;
    if (obs !== {4'hF, 7'h7F, 3'b100})
      $display("FAIL async_reset got %h required %h", obs, {4'hF, 7'h7F, 3'b100});
    else passed++;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    k = 0;
    clear_disp();
    cp_e = 1'b0;
    for (int n = 0; n < 45; n++) begin
      kk = k + 1;
      commit = (kk == 5);
      if (kk == 5) cp_e = 1'b1;
      if (kk == 32) cp_e = 1'b0;
      q.push_back(model(kk, en, cp_e));
      tick();
      e = q.pop_front();
      obs = {dig_n, seg_n, dp_n, frame_start, commit_pending};
      checks++;
      if (obs !== e) $display("FAIL post_reset k=%0d got %h required %h", k, obs, e);
      else passed++;
    end
    commit = 1'b0;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_scan();
    test_commit();
    test_commit_on_wrap();
    test_back_to_back();
    test_en_off();
    test_out_of_range();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached, passed %0d of %0d", passed, checks);
    $fatal(1);
  end

endmodule
